done_event_logger: RTL

Downstream consumer of the counting controller's completion output `g`. Each rising edge of `g` is captured as an event, stamped with a free-running cycle timer and queued in a small FIFO. The FIFO is drained by a valid/ready consumer (host or display stage). The block also keeps a saturating event count and a sticky overflow flag, so a slow consumer never silently loses information.

---
 rtl/logger_pkg.sv | 15 +
 rtl/sync_fifo.sv | 58 +++++
 rtl/done_event_logger.sv | 95 +++++++++
 3 files changed

// File: rtl/logger_pkg.sv
// Shared defaults and helpers for the done-event logger and its FIFO.
package logger_pkg;

    localparam int DEFAULT_DEPTH = 4;
    localparam int DEFAULT_TS_W  = 12;
    localparam int DEFAULT_CNT_W = 8;

    // Saturating increment for any counter up to 32 bits; the caller truncates the result.
    function automatic logic [31:0] sat_inc(input logic [31:0] value, input int unsigned width);
        logic [31:0] max_v;
        max_v = (width >= 32) ? 32'hFFFF_FFFF : ((32'd1 << width) - 32'd1);
        return (value >= max_v) ? value : value + 32'd1;
    endfunction

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with occupancy-based full/empty and registered, reset-cleared storage.
module sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4,
    localparam int PTR_W = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout,
    output logic             full,
    output logic             empty,
    output logic [PTR_W:0]   level
);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q;
    logic [PTR_W-1:0] rd_ptr_q;
    logic [PTR_W:0]   count_q;
    logic             do_push;
    logic             do_pop;

    assign full  = (count_q == (PTR_W + 1)'(DEPTH));
    assign empty = (count_q == '0);
    assign level = count_q;
    assign dout  = mem_q[rd_ptr_q];

    // A push into a full FIFO is legal only when the head leaves in the same cycle.
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            if (do_push) begin
                mem_q[wr_ptr_q] <= din;
                wr_ptr_q        <= wr_ptr_q + 1'b1;
            end
            if (do_pop) begin
                rd_ptr_q <= rd_ptr_q + 1'b1;
            end
            case ({do_push, do_pop})
                2'b10:   count_q <= count_q + 1'b1;
                2'b01:   count_q <= count_q - 1'b1;
                default: count_q <= count_q;
            endcase
        end
    end

endmodule

// File: rtl/done_event_logger.sv
// Captures rising edges of the controller's completion flag, timestamps them and queues
// them for a valid/ready consumer, with saturating event/drop counters and a sticky overflow.
module done_event_logger
    import logger_pkg::*;
#(
    parameter int DEPTH = DEFAULT_DEPTH,
    parameter int TS_W  = DEFAULT_TS_W,
    parameter int CNT_W = DEFAULT_CNT_W
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   g,
    input  logic                   clear,
    input  logic                   out_ready,
    output logic                   out_valid,
    output logic [TS_W-1:0]        out_ts,
    output logic [$clog2(DEPTH):0] level,
    output logic [CNT_W-1:0]       evt_cnt,
    output logic [CNT_W-1:0]       drop_cnt,
    output logic                   overflow
);

    logic [TS_W-1:0]  timer_q;
    logic             g_prev_q;
    logic [CNT_W-1:0] evt_cnt_q, evt_cnt_d;
    logic [CNT_W-1:0] drop_cnt_q, drop_cnt_d;
    logic             overflow_q, overflow_d;

    logic event_hit;
    logic pop;
    logic fifo_full;
    logic fifo_empty;
    logic accept;
    logic drop;

    // Handshake: the head entry transfers on a rising edge where out_valid && out_ready;
    // out_valid never depends on out_ready and does not drop until the entry is taken.
    assign event_hit = g && !g_prev_q;
    assign out_valid = !fifo_empty;
    assign pop       = out_valid && out_ready;
    assign drop      = event_hit && fifo_full && !pop;
    assign accept    = event_hit && !drop;

    sync_fifo #(
        .WIDTH (TS_W),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk   (clk),
        .reset (reset),
        .push  (event_hit),
        .pop   (pop),
        .din   (timer_q),
        .dout  (out_ts),
        .full  (fifo_full),
        .empty (fifo_empty),
        .level (level)
    );

    always_comb begin
        evt_cnt_d  = evt_cnt_q;
        drop_cnt_d = drop_cnt_q;
        overflow_d = overflow_q;
        if (clear) begin
            evt_cnt_d  = '0;
            drop_cnt_d = '0;
            overflow_d = 1'b0;
        end else if (accept) begin
            evt_cnt_d = CNT_W'(sat_inc(32'(evt_cnt_q), CNT_W));
        end else if (drop) begin
            drop_cnt_d = CNT_W'(sat_inc(32'(drop_cnt_q), CNT_W));
            overflow_d = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            timer_q    <= '0;
            g_prev_q   <= 1'b0;
            evt_cnt_q  <= '0;
            drop_cnt_q <= '0;
            overflow_q <= 1'b0;
        end else begin
            timer_q    <= timer_q + 1'b1;
            g_prev_q   <= g;
            evt_cnt_q  <= evt_cnt_d;
            drop_cnt_q <= drop_cnt_d;
            overflow_q <= overflow_d;
        end
    end

    assign evt_cnt  = evt_cnt_q;
    assign drop_cnt = drop_cnt_q;
    assign overflow = overflow_q;

endmodule
